// File: rtl/dds_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dds_spi_sequencer
//  Description : Command-level controller for the DDS SPI byte engine. Sends
//                an instruction byte plus 1-4 data bytes per accepted command,
//                collects read-back bytes, and optionally strobes IO_UPDATE
//                after a write. Aborts with err if a CS edge never arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_spi_sequencer #(
    parameter int GAP_CYCLES    = 2,
    parameter int UPDATE_CYCLES = 4,
    parameter int TIMEOUT       = 255,
    parameter int TO_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [4:0]  cmd_addr,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_data,
    input  logic        cmd_update,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic        spi_cs,
    input  logic [7:0]  spi_rx,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        io_update
);

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int c_UPD_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_UPD_W-1:0] c_UPD_LAST = c_UPD_W'(UPDATE_CYCLES - 1);
    localparam logic [TO_W-1:0]    c_TO_LAST  = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_GAP       = 3'd4,
        S_UPDATE    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_cs_s;
    logic               r_rw;
    logic               r_update;
    logic               r_is_data;
    logic [31:0]        r_data;
    logic [2:0]         r_remaining;
    logic [7:0]         r_tx;
    logic [31:0]        r_rd_data;
    logic               r_err;
    logic [TO_W-1:0]    r_to_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_UPD_W-1:0] r_upd_cnt;

    logic               w_accept;
    logic               w_to_hit;
    logic               w_gap_end;
    logic               w_upd_end;
    logic [7:0]         w_next_byte;

    // Engine CS is registered once; all decisions use the registered copy
    always_ff @(posedge clk) begin
        if (rst) r_cs_s <= 1'b1;
        else     r_cs_s <= spi_cs;
    end

    // Held low through reset so nothing is accepted while rst is asserted
    assign cmd_ready = (r_state == S_IDLE) && r_cs_s && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_to_hit  = (r_to_cnt == c_TO_LAST);
    assign w_gap_end = (r_gap_cnt == c_GAP_LAST);
    assign w_upd_end = (r_upd_cnt == c_UPD_LAST);

    assign spi_start = (r_state == S_START);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign io_update = (r_state == S_UPDATE);
    assign spi_tx    = r_tx;
    assign rd_data   = r_rd_data;
    assign err       = r_err;

    // Next data byte, MSB-first among the bytes still to send
    always_comb begin
        w_next_byte = r_data[7:0];
        case (r_remaining)
            3'd4:    w_next_byte = r_data[31:24];
            3'd3:    w_next_byte = r_data[23:16];
            3'd2:    w_next_byte = r_data[15:8];
            default: w_next_byte = r_data[7:0];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; a CS edge takes priority over the timeout on the same cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next_state = S_START;
            S_START:     w_next_state = S_WAIT_LOW;
            S_WAIT_LOW:  if (!r_cs_s)     w_next_state = S_WAIT_HIGH;
                         else if (w_to_hit) w_next_state = S_DONE;
            S_WAIT_HIGH: if (r_cs_s)      w_next_state = S_GAP;
                         else if (w_to_hit) w_next_state = S_DONE;
            S_GAP: begin
                if (w_gap_end) begin
                    if (r_remaining != 3'd0)     w_next_state = S_START;
                    else if (!r_rw && r_update)  w_next_state = S_UPDATE;
                    else                         w_next_state = S_DONE;
                end
            end
            S_UPDATE:    if (w_upd_end) w_next_state = S_DONE;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Command latch, byte sequencing, read-back capture and cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw        <= 1'b0;
            r_update    <= 1'b0;
            r_is_data   <= 1'b0;
            r_data      <= 32'd0;
            r_remaining <= 3'd0;
            r_tx        <= 8'd0;
            r_rd_data   <= 32'd0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_upd_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rw        <= cmd_rw;
                        r_update    <= cmd_update;
                        r_data      <= cmd_data;
                        r_remaining <= {1'b0, cmd_len} + 3'd1;
                        r_rd_data   <= 32'd0;
                        r_err       <= 1'b0;
                        r_is_data   <= 1'b0;
                        r_tx        <= {cmd_rw, 2'b00, cmd_addr};
                    end
                end
                S_START: r_to_cnt <= '0;
                S_WAIT_LOW: begin
                    if (!r_cs_s)       r_to_cnt <= '0;
                    else if (w_to_hit) r_err    <= 1'b1;
                    else               r_to_cnt <= r_to_cnt + TO_W'(1);
                end
                S_WAIT_HIGH: begin
                    if (r_cs_s) begin
                        // The instruction byte's MISO content is meaningless
                        if (r_is_data) begin
                            if (r_rw) r_rd_data <= {r_rd_data[23:0], spi_rx};
                            r_remaining <= r_remaining - 3'd1;
                        end
                        r_gap_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        if (r_remaining != 3'd0) begin
                            r_tx      <= w_next_byte;
                            r_is_data <= 1'b1;
                        end
                        r_upd_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                S_UPDATE: if (!w_upd_end) r_upd_cnt <= r_upd_cnt + c_UPD_W'(1);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_spi_sequencer
//  Description : Directed bench for dds_spi_sequencer with a behavioural byte
//                engine (CS low 2 cycles after start, for 8 cycles) and a
//                negedge monitor that tallies starts, done pulses and strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dds_spi_sequencer;

    localparam int GAP_CYCLES    = 2;
    localparam int UPDATE_CYCLES = 4;
    localparam int TIMEOUT       = 255;
    localparam int TO_W          = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [4:0]  cmd_addr;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        cmd_update;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_cs;
    logic [7:0]  spi_rx;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic        busy;
    logic        io_update;

    always #5 clk = ~clk;

    dds_spi_sequencer #(
        .GAP_CYCLES    (GAP_CYCLES),
        .UPDATE_CYCLES (UPDATE_CYCLES),
        .TIMEOUT       (TIMEOUT),
        .TO_W          (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .cmd_update (cmd_update),
        .spi_start  (spi_start),
        .spi_tx     (spi_tx),
        .spi_cs     (spi_cs),
        .spi_rx     (spi_rx),
        .rd_data    (rd_data),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .io_update  (io_update)
    );

    int checks = 0;
    int errors = 0;

    // Engine model state
    logic        stuck = 1'b0;
    logic [7:0]  mosi_log [0:63];
    logic [7:0]  miso_tab [0:63];
    int          n_starts = 0;

    // Monitor state
    int          cyc = 0;
    int          n_accepts = 0;
    int          n_done = 0;
    int          upd_total = 0;
    int          upd_run = 0;
    int          upd_run_at_done = 0;
    int          overlap = 0;
    int          accept_cyc = 0;
    int          last_lat = -1;
    logic        lat_pending = 1'b0;
    int          last_start_cyc = 0;
    int          last_done_cyc = 0;
    int          last_rise_cyc = 0;
    logic        rise_seen = 1'b0;
    int          min_gap = 1000;
    logic        prev_cs = 1'b1;
    logic        last_done_err = 1'b0;
    logic [31:0] last_done_rd = 32'd0;

    // Byte engine model
    initial begin
        int idx;
        spi_cs = 1'b1;
        spi_rx = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                idx = n_starts;
                mosi_log[idx] = spi_tx;
                n_starts++;
                if (!stuck) begin
                    repeat (2) @(posedge clk);
                    #1 spi_cs = 1'b0;
                    repeat (8) @(posedge clk);
                    #1 spi_rx = miso_tab[idx];
                    spi_cs = 1'b1;
                end
            end
        end
    end

    // Monitor sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cmd_valid && cmd_ready) begin
                n_accepts++;
                accept_cyc  = cyc;
                lat_pending = 1'b1;
            end
            if (spi_start) begin
                if (lat_pending) begin
                    last_lat    = cyc - accept_cyc;
                    lat_pending = 1'b0;
                end
                last_start_cyc = cyc;
                if (rise_seen) begin
                    if (cyc - last_rise_cyc < min_gap) min_gap = cyc - last_rise_cyc;
                    rise_seen = 1'b0;
                end
                if (!spi_cs) overlap++;
            end
            if (spi_cs && !prev_cs) begin
                last_rise_cyc = cyc;
                rise_seen     = 1'b1;
            end
            prev_cs = spi_cs;
            if (done) begin
                n_done++;
                upd_run_at_done = upd_run;
                last_done_cyc   = cyc;
                last_done_err   = err;
                last_done_rd    = rd_data;
            end
            upd_run = io_update ? upd_run + 1 : 0;
            if (io_update) upd_total++;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic rw, input logic [4:0] addr, input logic [1:0] len,
                             input logic [31:0] data, input logic upd);
        int acc0;
        int t;
        acc0 = n_accepts;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_rw     = rw;
        cmd_addr   = addr;
        cmd_len    = len;
        cmd_data   = data;
        cmd_update = upd;
        t = 0;
        while (n_accepts == acc0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1 cmd_valid = 1'b0;
        check("accept", 32'(n_accepts - acc0), 32'd1);
    endtask

    task automatic wait_done(input int d0, input int limit);
        int t;
        t = 0;
        while (n_done == d0 && t < limit) begin
            @(posedge clk);
            t++;
        end
        check("done_pulse", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        int s0;
        int d0;
        int u0;
        int a0;
        int t;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_rw     = 1'b0;
        cmd_addr   = 5'd0;
        cmd_len    = 2'd0;
        cmd_data   = 32'd0;
        cmd_update = 1'b0;
        for (int i = 0; i < 64; i++) miso_tab[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_spi_tx",    32'(spi_tx),    32'd0);
        check("rst_rd_data",   rd_data,        32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_io_update", 32'(io_update), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single-byte write, no update
        s0 = n_starts; d0 = n_done; u0 = upd_total;
        start_cmd(1'b0, 5'h04, 2'd0, 32'h0000_00A5, 1'b0);
        wait_done(d0, 500);
        check("w1_starts",  32'(n_starts - s0), 32'd2);
        check("w1_instr",   32'(mosi_log[s0]),     32'h04);
        check("w1_data",    32'(mosi_log[s0 + 1]), 32'hA5);
        check("w1_err",     32'(last_done_err),    32'd0);
        check("w1_no_upd",  32'(upd_total - u0),   32'd0);
        check("w1_latency", 32'(last_lat),         32'd1);

        // Four-byte write with IO_UPDATE
        s0 = n_starts; d0 = n_done; u0 = upd_total;
        start_cmd(1'b0, 5'h04, 2'd3, 32'h1234_5678, 1'b1);
        wait_done(d0, 1000);
        check("w4_starts", 32'(n_starts - s0), 32'd5);
        check("w4_b0", 32'(mosi_log[s0]),     32'h04);
        check("w4_b1", 32'(mosi_log[s0 + 1]), 32'h12);
        check("w4_b2", 32'(mosi_log[s0 + 2]), 32'h34);
        check("w4_b3", 32'(mosi_log[s0 + 3]), 32'h56);
        check("w4_b4", 32'(mosi_log[s0 + 4]), 32'h78);
        check("w4_gap_ok", 32'(min_gap >= GAP_CYCLES), 32'd1);
        check("w4_upd_before_done", 32'(upd_run_at_done), 32'(UPDATE_CYCLES));
        check("w4_upd_total", 32'(upd_total - u0), 32'(UPDATE_CYCLES));
        check("w4_err", 32'(last_done_err), 32'd0);

        // CS stuck high: timeout abort, no update even though requested
        stuck = 1'b1;
        s0 = n_starts; d0 = n_done; u0 = upd_total;
        start_cmd(1'b0, 5'h05, 2'd0, 32'h0000_0077, 1'b1);
        wait_done(d0, 700);
        check("to_starts", 32'(n_starts - s0), 32'd1);
        check("to_err", 32'(last_done_err), 32'd1);
        check("to_latency", 32'(last_done_cyc - last_start_cyc), 32'(TIMEOUT + 2));
        check("to_no_upd", 32'(upd_total - u0), 32'd0);
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("to_err_held", 32'(err), 32'd1);

        // Two-byte read with update requested (must be ignored)
        s0 = n_starts; d0 = n_done; u0 = upd_total;
        miso_tab[s0]     = 8'h55;
        miso_tab[s0 + 1] = 8'hDE;
        miso_tab[s0 + 2] = 8'hAD;
        start_cmd(1'b1, 5'h01, 2'd1, 32'h0000_BEEF, 1'b1);
        wait_done(d0, 800);
        check("rd_instr", 32'(mosi_log[s0]),     32'h81);
        check("rd_b1",    32'(mosi_log[s0 + 1]), 32'hBE);
        check("rd_b2",    32'(mosi_log[s0 + 2]), 32'hEF);
        check("rd_data",  last_done_rd,          32'h0000_DEAD);
        check("rd_err",   32'(last_done_err),    32'd0);
        check("rd_no_upd", 32'(upd_total - u0),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rd_data_held", rd_data, 32'h0000_DEAD);

        // Reset during the third byte of a four-byte write
        s0 = n_starts; d0 = n_done;
        start_cmd(1'b0, 5'h06, 2'd3, 32'hCAFE_BABE, 1'b1);
        t = 0;
        while (!(n_starts >= s0 + 3 && spi_cs == 1'b0) && t < 600) begin
            @(posedge clk);
            t++;
        end
        check("mr_third_byte_seen", 32'(n_starts - s0), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_busy",      32'(busy),      32'd0);
        check("mr_done",      32'(done),      32'd0);
        check("mr_io_update", 32'(io_update), 32'd0);
        check("mr_spi_start", 32'(spi_start), 32'd0);
        check("mr_cs_low",    32'(spi_cs),    32'd0);
        rst = 1'b0;
        t = 0;
        while (spi_cs == 1'b0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("mr_ready_back", 32'(cmd_ready), 32'd1);
        check("mr_no_done",    32'(n_done - d0), 32'd0);
        s0 = n_starts; d0 = n_done;
        start_cmd(1'b0, 5'h07, 2'd0, 32'h0000_005A, 1'b0);
        wait_done(d0, 500);
        check("mr_new_instr", 32'(mosi_log[s0]),     32'h07);
        check("mr_new_data",  32'(mosi_log[s0 + 1]), 32'h5A);
        check("mr_new_err",   32'(last_done_err),    32'd0);

        // Two writes queued behind a continuously high cmd_valid
        s0 = n_starts; d0 = n_done; a0 = n_accepts;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_rw     = 1'b0;
        cmd_addr   = 5'h02;
        cmd_len    = 2'd0;
        cmd_data   = 32'h0000_0011;
        cmd_update = 1'b0;
        t = 0;
        while (n_accepts == a0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        cmd_addr = 5'h03;
        cmd_len  = 2'd1;
        cmd_data = 32'h0000_2233;
        while (n_accepts == a0 + 1 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1 cmd_valid = 1'b0;
        t = 0;
        while (n_done < d0 + 2 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (20) @(posedge clk);
        check("q_accepts", 32'(n_accepts - a0), 32'd2);
        check("q_dones",   32'(n_done - d0),    32'd2);
        check("q_starts",  32'(n_starts - s0),  32'd5);
        check("q_a_instr", 32'(mosi_log[s0]),     32'h02);
        check("q_a_data",  32'(mosi_log[s0 + 1]), 32'h11);
        check("q_b_instr", 32'(mosi_log[s0 + 2]), 32'h03);
        check("q_b_d1",    32'(mosi_log[s0 + 3]), 32'h22);
        check("q_b_d2",    32'(mosi_log[s0 + 4]), 32'h33);
        check("q_no_overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
